// File: rtl/spi_master.sv
// spi_master: SPI bus master, NBYTES-wide frames, MSB first, all four cpol/cpha modes.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_master #(
    parameter int NBYTES = 1,
    parameter int CLKDIV = 4,
    parameter int GAP    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   din,
    output logic [8*NBYTES-1:0]   dout,
    output logic                  busy,
    output logic                  done,
    output logic                  select,
    output logic                  mclk,
    output logic                  mosi,
    input  logic                  miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic                  loopback
`endif
);

    localparam int N     = 8 * NBYTES;
    localparam int EDGES = 16 * NBYTES;
    localparam int WW    = $clog2(GAP + 1);
    localparam int HW    = $clog2(CLKDIV + 1);
    localparam int EW    = $clog2(EDGES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [HW-1:0] half_q, half_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          cpha_q, cpha_d;
    logic          mclk_q, mclk_d;
    logic          mosi_q, mosi_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sample_bit;
    logic          leading;

    // Select the bit shifted into sr on a sampling edge
`ifdef SPI_MASTER_LOOPBACK_EN
    always_comb begin
        sample_bit = loopback ? mosi_q : miso;
    end
`else
    always_comb begin
        sample_bit = miso;
    end
`endif

    // Register all state; reset abandons any frame in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            half_q  <= '0;
            edge_q  <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            cpha_q  <= 1'b0;
            mclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            half_q  <= half_d;
            edge_q  <= edge_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            cpha_q  <= cpha_d;
            mclk_q  <= mclk_d;
            mosi_q  <= mosi_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: frame sequencing, mclk generation and shifting
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        half_d  = half_q;
        edge_d  = edge_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        cpha_d  = cpha_q;
        mclk_d  = mclk_q;
        mosi_d  = mosi_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // Edges count down from an even total, so odd edges see an even count
        leading = ~edge_q[0];
        unique case (state_q)
            IDLE: begin
                sel_d  = 1'b0;
                busy_d = 1'b0;
                mclk_d = cpol;
                if (start) begin
                    sr_d    = din;
                    cpha_d  = cpha;
                    sel_d   = 1'b1;
                    mosi_d  = din[N-1];
                    busy_d  = 1'b1;
                    wait_d  = WW'(GAP);
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (wait_q == WW'(1)) begin
                    half_d  = HW'(CLKDIV);
                    edge_d  = EW'(EDGES);
                    state_d = SHIFT;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            SHIFT: begin
                if (half_q == HW'(1)) begin
                    mclk_d = ~mclk_q;
                    edge_d = edge_q - EW'(1);
                    half_d = HW'(CLKDIV);
                    if (leading) begin
                        if (!cpha_q) begin
                            sr_d = {sr_q[N-2:0], sample_bit};
                        end else begin
                            mosi_d = sr_q[N-1];
                        end
                    end else begin
                        if (cpha_q) begin
                            sr_d = {sr_q[N-2:0], sample_bit};
                        end else if (edge_q != EW'(1)) begin
                            mosi_d = sr_q[N-1];
                        end
                    end
                    if (edge_q == EW'(1)) begin
                        wait_d  = WW'(GAP);
                        state_d = TRAIL;
                    end
                end else begin
                    half_d = half_q - HW'(1);
                end
            end
            TRAIL: begin
                if (wait_q == WW'(1)) begin
                    sel_d   = 1'b0;
                    dout_d  = sr_q;
                    done_d  = 1'b1;
                    wait_d  = WW'(GAP);
                    state_d = HOLD;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            HOLD: begin
                if (wait_q == WW'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout   = dout_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign select = sel_q;
    assign mclk   = mclk_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames against a behavioural SPI slave model.
// Checks data both ways, edge counts, busy length, done pulses and reset abort.
module tb_spi_master;

    localparam int NB = 2;
    localparam int CD = 3;
    localparam int GP = 5;
    localparam int W  = 8 * NB;
    localparam int BUSY_CYC = 3 * GP + 16 * NB * CD;
    localparam int LIMIT = 5000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpol = 1'b0;
    logic         cpha = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         busy;
    logic         done;
    logic         select;
    logic         mclk;
    logic         mosi;
    logic         miso_m = 1'b0;
    logic         tie0 = 1'b0;
    logic         miso_pin;
    logic         lb = 1'b0;

    int checks = 0;
    int failures = 0;

    // slave model state
    logic [W-1:0] s_tx = '0;
    logic [W-1:0] s_rx = '0;
    logic         t_cpha = 1'b0;
    int           s_edges = 0;
    int           txi = 0;

    int busy_cnt = 0;
    int done_cnt = 0;
    int rise_cnt = 0;

    assign miso_pin = tie0 ? 1'b0 : miso_m;

    always #5 clk = ~clk;

    spi_master #(.NBYTES(NB), .CLKDIV(CD), .GAP(GP)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpol    (cpol),
        .cpha    (cpha),
        .start   (start),
        .din     (din),
        .dout    (dout),
        .busy    (busy),
        .done    (done),
        .select  (select),
        .mclk    (mclk),
        .mosi    (mosi),
        .miso    (miso_pin)
`ifdef SPI_MASTER_LOOPBACK_EN
        ,
        .loopback(lb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave: first bit ready at select for cpha=0
    always @(posedge select) begin
        s_edges = 0;
        txi = 0;
        s_rx = '0;
        #1;
        if (!t_cpha) begin
            miso_m = s_tx[W-1];
            txi = 1;
        end
    end

    // Slave: shift out on the driving edge, capture on the other
    always @(mclk) begin
        if (select) begin
            #1;
            s_edges++;
            if (s_edges % 2 == 1) begin
                if (!t_cpha) s_rx = {s_rx[W-2:0], mosi};
                else if (txi < W) begin
                    miso_m = s_tx[W-1-txi];
                    txi++;
                end
            end else begin
                if (t_cpha) s_rx = {s_rx[W-2:0], mosi};
                else if (txi < W) begin
                    miso_m = s_tx[W-1-txi];
                    txi++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    always @(posedge mclk) begin
        if (select) rise_cnt++;
    end

    task automatic run_frame(input logic pol, input logic pha,
                             input logic [W-1:0] d,
                             input logic [W-1:0] sd,
                             input int restart_at,
                             input bit scramble);
        int n;
        cpol = pol;
        cpha = pha;
        t_cpha = pha;
        s_tx = sd;
        repeat (3) @(negedge clk);
        check("idle_mclk", {31'b0, mclk}, {31'b0, pol});
        check("idle_sel", {31'b0, select}, 32'd0);
        busy_cnt = 0;
        done_cnt = 0;
        rise_cnt = 0;
        din = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < LIMIT) begin
            start = (n == restart_at);
            if (start) din = '1;
            if (scramble) begin
                cpol = 1'($urandom);
                cpha = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("timeout", {31'b0, n < LIMIT}, 32'd1);
        check("dout", 32'(dout), 32'(sd));
        check("slave_rx", 32'(s_rx), 32'(d));
        check("done_cnt", done_cnt, 32'd1);
        check("busy_cyc", busy_cnt, BUSY_CYC);
        check("rises", rise_cnt, 8 * NB);
    endtask

    initial begin
        logic [1:0] m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;
        #1;
        check("rst_sel", {31'b0, select}, 32'd0);
        check("rst_mclk", {31'b0, mclk}, 32'd0);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_frame(1'b0, 1'b0, 16'h00A5, 16'h003C, -1, 1'b0);
        run_frame(1'b1, 1'b1, 16'h1234, 16'hBEEF, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            m = 2'($urandom_range(0, 3));
            a = W'($urandom);
            b = W'($urandom);
            run_frame(m[1], m[0], a, b, -1, 1'b1);
        end

        // start during SHIFT must be ignored
        run_frame(1'b0, 1'b1, 16'h5AC3, 16'h0F0F, GP + 10, 1'b0);

        // reset in the middle of SHIFT
        cpol = 1'b1;
        cpha = 1'b0;
        t_cpha = 1'b0;
        s_tx = 16'h1111;
        repeat (3) @(negedge clk);
        done_cnt = 0;
        din = 16'h7777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (GP + 12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_sel", {31'b0, select}, 32'd0);
        check("ar_mclk", {31'b0, mclk}, 32'd0);
        check("ar_busy", {31'b0, busy}, 32'd0);
        check("ar_dout", 32'(dout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (BUSY_CYC + 10) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("ar_done", done_cnt, 32'd0);
        check("ar_idle", n, 32'd0);
        run_frame(1'b1, 1'b0, 16'hC001, 16'h4D2E, -1, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
        lb = 1'b1;
        tie0 = 1'b1;
        run_frame(1'b0, 1'b0, 16'h0096, 16'h0096, -1, 1'b0);
        run_frame(1'b1, 1'b1, 16'hA596, 16'hA596, -1, 1'b0);
        lb = 1'b0;
        tie0 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus master: the initiating end of the same serial link handled by spi_slave.
- Drives select (active high), mclk and mosi, and samples miso.
- Shifts an NBYTES-wide frame MSB first, in any of the four cpol/cpha modes.
- Sits between a local controller (start/din in; done/dout out) and external SPI slaves, including spi_slave instances in the same fabric.

Parameters:
- NBYTES, 1, frame length in bytes; frame = 8*NBYTES bits.
- CLKDIV, 4, clk cycles per mclk half-period; must be >= 2.
- GAP, 8, clk cycles for each of: select-to-first-edge, last-edge-to-deselect, and minimum deselect time.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpol  input  1  mclk idle level; latched at start.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched at start.
- start  input  1  one-cycle request; ignored while busy.
- din  input  8*NBYTES  frame to transmit; latched on accepted start.
- dout  output  8*NBYTES  frame received; valid from done onward.
- busy  output  1  high from the cycle after an accepted start until back in IDLE.
- done  output  1  one-cycle pulse when the frame is complete.
- select  output  1  chip select, active high.
- mclk  output  1  SPI clock.
- mosi  output  1  master data out.
- miso  input  1  slave data in; treated as synchronous to the mclk edges this block generates.

Behaviour:
- Reset (async, any state):
  - select=0, mclk=0, mosi=0, busy=0, done=0, dout=0; state=IDLE.
  - A frame in progress is abandoned; no done pulse is produced.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> HOLD -> IDLE.
- IDLE:
  - select=0, mclk follows the cpol input every cycle, busy=0.
  - On start: latch din into shift register sr, latch cpol/cpha, and set select=1, mosi=din[MSB], busy=1.
  - Next state LEAD, with the wait counter loaded to GAP.
- LEAD:
  - Hold for GAP cycles, then enter SHIFT.
  - Load the half-period counter to CLKDIV and the edge counter to 16*NBYTES.
- SHIFT:
  - When the half-period counter expires: toggle mclk, decrement the edge counter, reload CLKDIV.
  - Odd-numbered edges (1st, 3rd, ...) are leading edges; even-numbered edges are trailing edges.
  - cpha=0:
    - Leading edge: sr <= {sr[N-2:0], miso}.
    - Trailing edge, except the final edge: mosi <= sr[MSB] (post-shift value).
  - cpha=1:
    - Leading edge: mosi <= sr[MSB].
    - Trailing edge: sr <= {sr[N-2:0], miso}.
  - After edge 16*NBYTES, mclk equals cpol; go to TRAIL with the wait counter at GAP.
- TRAIL:
  - Hold for GAP cycles.
  - Then, in one cycle: select=0, dout<=sr, done=1. Go to HOLD with the wait counter at GAP.
- HOLD:
  - busy stays 1 and select stays 0 for GAP cycles, then go to IDLE.
  - This guarantees a minimum deselect time, so the slave's select synchroniser sees a clean edge.
- Total busy time: GAP + 16*NBYTES*CLKDIV + GAP + GAP cycles; done is asserted exactly once per accepted start.
- start while busy (any state other than IDLE) is ignored. start in the same cycle HOLD exits is also ignored.
- cpol/cpha changes during a frame have no effect until the next start.
- mosi holds its last value outside frames.
- Counter widths: $clog2-sized; the edge counter must hold 16*NBYTES.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the internal sample source is mosi instead of miso, so dout == din after done.
  - External pins behave identically in both cases.
- Undefined: no loopback port; the sample source is always miso.

Test Plan:
- Mode 0, NBYTES=1, CLKDIV=2, GAP=8, din=0xA5, slave model returns 0x3C:
  - Exactly 8 rising edges.
  - mosi sampled on rising edges gives 0xA5.
  - dout=0x3C; done high for 1 cycle.
  - busy high for 8+32+8+8=56 cycles.
- Mode 3 (cpol=1, cpha=1), NBYTES=2, din=0x1234, slave returns 0xBEEF:
  - mclk idles high.
  - Master samples on rising (trailing) edges.
  - dout=0xBEEF; 16 rising edges.
- start pulsed again mid-SHIFT with din=0xFF:
  - Ignored; only one done pulse.
  - Transmitted data is still the original din.
- reset asserted during SHIFT:
  - Same cycle: select=0, mclk=0, busy=0, dout=0.
  - No done pulse.
  - A subsequent start completes normally.
- Back-to-back against spi_slave (NBYTES=1, slave clk = master clk, CLKDIV=4), all four modes, master din=0x5A, slave din=0xC3:
  - Master dout=0xC3.
  - Slave dout=0x5A.
  - Each side's done pulses once.
- SPI_MASTER_LOOPBACK_EN defined, loopback=1, din=0x96, miso tied 0: dout=0x96.
